// File: rtl/mux12_rr_arbiter.sv
// mux12_rr_arbiter
// Round-robin arbiter that owns the select of a 12:1 mux. One requester at a time is granted
// ownership until it signals done, withdraws its request, or holds for MAX_HOLD cycles.
// Every release is followed by at least one idle cycle before the next grant.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous active-high reset, overrides all other inputs
//   req     in  12   request lines, req[k] asks for mux input k
//   done    in   1   current owner finished, only looked at while busy
//   sel     out  4   registered mux select, always 0..11
//   gnt     out 12   registered one-hot grant
//   busy    out  1   high while a grant is active
//   timeout out  1   one-cycle pulse after a grant is force-released at MAX_HOLD
module mux12_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [11:0] gnt,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned NumReq   = 12;
  localparam logic [7:0]  MaxHoldW = 8'(MAX_HOLD);
  localparam logic [3:0]  LastIdx  = 4'(NumReq - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q;
  logic [3:0]  ptr_q;
  logic [7:0]  hcnt_q;
  logic [3:0]  sel_q;
  logic [11:0] gnt_q;
  logic        busy_q;
  logic        timeout_q;

  // Winner of the rotating search starting at ptr_q.
  logic [3:0]  win_idx;
  logic        win_found;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      logic [4:0] cand;
      cand = 5'(ptr_q) + 5'(i);
      if (cand >= 5'(NumReq)) begin
        cand = cand - 5'(NumReq);
      end
      if (!win_found && req[cand[3:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[3:0];
      end
    end
  end

  // Release conditions while granted.
  logic owner_req;
  logic hold_hit;
  logic release_now;
  logic timeout_only;
  logic [3:0] ptr_after;

  always_comb begin
    owner_req    = req[sel_q];
    hold_hit     = (hcnt_q == MaxHoldW);
    release_now  = done || !owner_req || hold_hit;
    // A simultaneous done or withdrawal makes it a normal release, not a timeout.
    timeout_only = hold_hit && !done && owner_req;
    ptr_after    = (sel_q == LastIdx) ? 4'd0 : sel_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      hcnt_q    <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            sel_q   <= win_idx;
            gnt_q   <= 12'(1) << win_idx;
            busy_q  <= 1'b1;
            hcnt_q  <= 8'd1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (release_now) begin
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            hcnt_q    <= '0;
            ptr_q     <= ptr_after;
            timeout_q <= timeout_only;
            state_q   <= StIdle;
          end else begin
            hcnt_q <= hcnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/mux12_rr_arbiter.md
MUX12_RR_ARBITER -- requirements
Module: mux12_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum number of consecutive cycles one grant may be held (legal range 1..255).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  12  request lines; req[k] asks for ownership of mux input k.
REQ-006 done  input  1  current owner finished; sampled only while busy=1.
REQ-007 sel  output  4  select code driven to the 12:1 mux; legal values 0..11 only.
REQ-008 gnt  output  12  one-hot grant; gnt[k]=1 means requester k owns the mux.
REQ-009 busy  output  1  high while a grant is active.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-011 The block SHALL implement two states, IDLE and GRANT, plus a 4-bit round-robin pointer ptr (0..11) and an 8-bit hold counter hcnt.
REQ-012 IDLE: if req=0, the block SHALL stay in IDLE with gnt=0, busy=0, and sel holding its last value.
REQ-013 IDLE with any req bit set: the block SHALL select the first k with req[k]=1, searching ptr, ptr+1, ... 11, 0, ... ptr-1 (mod 12).
REQ-014 The winning k SHALL be registered: sel=k, gnt[k]=1, busy=1, hcnt=1, state=GRANT on the edge after the request is sampled (1-cycle grant latency).
REQ-015 GRANT: sel and gnt SHALL stay constant; req changes on other lines SHALL have no effect.
REQ-016 GRANT: release SHALL occur on the edge where done=1 OR req[sel]=0 OR hcnt=MAX_HOLD.
REQ-017 On release: gnt=0, busy=0, state=IDLE, ptr=sel+1 with wrap 11->0; sel keeps the released value.
REQ-018 If release is due only to hcnt=MAX_HOLD (done=0, req[sel]=1), timeout SHALL be 1 for exactly the cycle after that edge; otherwise timeout=0.
REQ-019 Without a release condition, hcnt SHALL increment by 1 each GRANT cycle; it never exceeds MAX_HOLD.
REQ-020 Simultaneous done=1 and hcnt=MAX_HOLD SHALL count as a normal release (timeout=0).
REQ-021 Each release SHALL be followed by at least one IDLE cycle; the earliest next grant is visible 2 cycles after the release edge.
REQ-022 The block SHALL never assert more than one gnt bit and SHALL never drive sel>11.
REQ-023 A requester released by timeout SHALL be last in priority for the next arbitration (pointer advance per REQ-017).

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, ptr=0, hcnt=0, sel=0, gnt=0, busy=0, timeout=0; all outputs take these values in the cycle after that edge.
REQ-025 Reset mid-GRANT SHALL drop the grant immediately with no timeout pulse; rst SHALL take priority over every other input.
REQ-026 While rst=1, req and done SHALL be ignored.

Verification
REQ-027 After reset, req=12'h001 -> next cycle sel=0, gnt=12'h001, busy=1; done=1 for one cycle -> gnt=0, busy=0, ptr=1.
REQ-028 Fairness: req=12'hFFF held, done pulsed each grant -> grant order 0,1,2,...,11,0 with one IDLE cycle between grants.
REQ-029 Wrap: ptr=11 (after granting 10), req=12'h801|12'h001 -> grant 11, then grant 0 after release.
REQ-030 Timeout: MAX_HOLD=4, req[5] held, done=0 -> gnt[5] for exactly 4 cycles, timeout pulse 1 cycle, then req[5]|req[6] -> grant 6 first.
REQ-031 Requester withdraws: grant 3 active, req[3] drops -> gnt=0 next cycle, timeout=0, ptr=4.
REQ-032 rst=1 during GRANT with hcnt=3 -> next cycle all outputs zero, ptr=0; with req=12'h800 after rst deasserts, grant 11 follows 1 cycle later.
